// File: rtl/operand_fetch.sv
// operand_fetch: streams (A,B) operand pairs out of a registered-read data memory.
// Latency: 3 cycles from REQ_A entry to op_valid; one pair per 4 cycles when op_ready stays high.
// Backpressure: op_valid/op_a/op_b hold in HOLD until op_ready; port_we=1 freezes the read states.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, base_*, stride_*, len  burst request; sampled only in IDLE
//   port_we                  data-memory write enable; the read port is unavailable while high
//   r_addr / r_data          read address out, registered read data in (one cycle later)
//   op_a, op_b, op_valid, op_ready  operand-pair output handshake
//   busy, done               activity flag and one-cycle end-of-burst pulse
module operand_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] stride_a,
  input  logic [ADDR_WIDTH-1:0] stride_b,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic                  port_we,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_A = 3'd1,
    REQ_B = 3'd2,
    CAP_B = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
  logic [ADDR_WIDTH-1:0] stride_a_q, stride_b_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
  logic                  op_valid_q, busy_q, done_q;

  // Next-pair addresses and remaining count; sums wrap modulo 2**ADDR_WIDTH.
  logic [ADDR_WIDTH-1:0] addr_a_d, addr_b_d, count_d;
  logic                  xfer;

  assign addr_a_d = addr_a_q + stride_a_q;
  assign addr_b_d = addr_b_q + stride_b_q;
  assign count_d  = count_q - ADDR_WIDTH'(1);
  assign xfer     = op_valid_q & op_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      count_q    <= '0;
      r_addr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              addr_a_q   <= base_a;
              addr_b_q   <= base_b;
              stride_a_q <= stride_a;
              stride_b_q <= stride_b;
              count_q    <= len;
              r_addr_q   <= base_a;
              busy_q     <= 1'b1;
              state_q    <= REQ_A;
            end else begin
              // Empty burst: acknowledge without touching memory.
              done_q <= 1'b1;
            end
          end
        end
        // While port_we is high the memory does not read, so each read state
        // simply repeats itself with the same address until the port frees up.
        REQ_A: begin
          if (!port_we) begin
            r_addr_q <= addr_b_q;
            state_q  <= REQ_B;
          end
        end
        REQ_B: begin
          if (!port_we) begin
            op_a_q  <= r_data;      // data for the A address issued in REQ_A
            state_q <= CAP_B;
          end
        end
        CAP_B: begin
          if (!port_we) begin
            op_b_q     <= r_data;   // data for the B address issued in REQ_B
            op_valid_q <= 1'b1;
            r_addr_q   <= '0;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (xfer) begin
            op_valid_q <= 1'b0;
            count_q    <= count_d;
            if (count_d == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              addr_a_q <= addr_a_d;
              addr_b_q <= addr_b_d;
              r_addr_q <= addr_a_d;
              state_q  <= REQ_A;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign r_addr   = r_addr_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_valid = op_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       rst, start, port_we, op_ready;
  logic [7:0] base_a, base_b, stride_a, stride_b, len;
  logic [7:0] r_addr, r_data, op_a, op_b;
  logic       op_valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic [15:0] pairs [$];

  always #5 clk = ~clk;

  operand_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_a(base_a), .base_b(base_b), .stride_a(stride_a), .stride_b(stride_b),
    .len(len), .port_we(port_we), .r_addr(r_addr), .r_data(r_data),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .busy(busy), .done(done)
  );

  // Registered-read memory; the read port does not update while port_we is high.
  always @(posedge clk) begin
    if (!port_we) r_data <= mem[r_addr];
  end

  // Record every transferred pair as {op_a, op_b}.
  always @(negedge clk) begin
    if (op_valid && op_ready) pairs.push_back({op_a, op_b});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input logic [7:0] ba, input logic [7:0] sa,
                             input logic [7:0] bb, input logic [7:0] sb,
                             input logic [7:0] l);
    base_a = ba; stride_a = sa; base_b = bb; stride_b = sb; len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!op_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_pairs(input string tag, input int n,
                             input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2);
    logic [15:0] exp [3];
    exp[0] = p0; exp[1] = p1; exp[2] = p2;
    check({tag, "_npairs"}, pairs.size(), n);
    for (int i = 0; i < n && i < pairs.size(); i++)
      check($sformatf("%s_pair%0d", tag, i), {16'd0, pairs[i]}, {16'd0, exp[i]});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    mem[10] = 8'd10; mem[11] = 8'd2; mem[12] = 8'd3; mem[13] = 8'd4;
    mem[14] = 8'd5;  mem[15] = 8'd6; mem[16] = 8'd1; mem[17] = 8'd2;
    mem[255] = 8'd77; mem[0] = 8'd99;

    rst = 1'b1; start = 1'b0; port_we = 1'b0; op_ready = 1'b1;
    base_a = '0; base_b = '0; stride_a = '0; stride_b = '0; len = '0;
    repeat (2) @(negedge clk);
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_r_addr", {24'd0, r_addr}, 32'd0);
    check("rst_op_a", {24'd0, op_a}, 32'd0);
    rst = 1'b0;

    // Sequential pairs, op_ready held high: (10,5) then (2,6).
    pairs.delete();
    start_burst(8'd10, 8'd1, 8'd14, 8'd1, 8'd2);
    check("b1_busy", {31'd0, busy}, 32'd1);
    check("b1_raddr_a", {24'd0, r_addr}, 32'd10);
    @(negedge clk);
    check("b1_raddr_b", {24'd0, r_addr}, 32'd14);
    wait_valid(n);
    check("b1_latency", n + 1, 32'd3);
    check("b1_op_a", {24'd0, op_a}, 32'd10);
    check("b1_op_b", {24'd0, op_b}, 32'd5);
    wait_done("b1");
    check_pairs("b1", 2, 16'h0A05, 16'h0206, 16'h0000);

    // Stride 2: (10,2), (3,4), (5,6).
    pairs.delete();
    start_burst(8'd10, 8'd2, 8'd11, 8'd2, 8'd3);
    wait_done("b2");
    check_pairs("b2", 3, 16'h0A02, 16'h0304, 16'h0506);

    // Backpressure: first pair held stable for 5 cycles.
    pairs.delete();
    op_ready = 1'b0;
    start_burst(8'd10, 8'd1, 8'd14, 8'd1, 8'd2);
    wait_valid(n);
    begin
      bit stable;
      stable = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (!(op_valid && op_a == 8'd10 && op_b == 8'd5)) stable = 1'b0;
      end
      check("bp_hold_stable", {31'd0, stable}, 32'd1);
    end
    check("bp_no_xfer", pairs.size(), 32'd0);
    op_ready = 1'b1;
    wait_done("bp");
    check_pairs("bp", 2, 16'h0A05, 16'h0206, 16'h0000);

    // port_we high for 2 cycles during REQ_B of the first pair.
    pairs.delete();
    start_burst(8'd10, 8'd1, 8'd14, 8'd1, 8'd2);
    @(negedge clk);
    check("we_raddr0", {24'd0, r_addr}, 32'd14);
    port_we = 1'b1;
    @(negedge clk);
    check("we_raddr1", {24'd0, r_addr}, 32'd14);
    @(negedge clk);
    check("we_raddr2", {24'd0, r_addr}, 32'd14);
    port_we = 1'b0;
    wait_valid(n);
    check("we_latency", n + 3, 32'd5);
    wait_done("we");
    check_pairs("we", 2, 16'h0A05, 16'h0206, 16'h0000);

    // len = 0: done pulse only, no read address.
    start_burst(8'd10, 8'd1, 8'd14, 8'd1, 8'd0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd0);
    check("len0_raddr", {24'd0, r_addr}, 32'd0);
    @(negedge clk);
    check("len0_done_once", {31'd0, done}, 32'd0);
    check("len0_raddr2", {24'd0, r_addr}, 32'd0);

    // start while busy is ignored.
    pairs.delete();
    start_burst(8'd12, 8'd1, 8'd13, 8'd1, 8'd1);
    start_burst(8'd10, 8'd1, 8'd14, 8'd1, 8'd2);
    wait_done("ign");
    check_pairs("ign", 1, 16'h0304, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    check("ign_idle", {31'd0, busy}, 32'd0);

    // Reset while holding a pair, then immediate restart.
    op_ready = 1'b0;
    start_burst(8'd10, 8'd1, 8'd14, 8'd1, 8'd2);
    wait_valid(n);
    check("hrst_valid_before", {31'd0, op_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("hrst_op_valid", {31'd0, op_valid}, 32'd0);
    check("hrst_op_a", {24'd0, op_a}, 32'd0);
    check("hrst_op_b", {24'd0, op_b}, 32'd0);
    check("hrst_busy", {31'd0, busy}, 32'd0);
    check("hrst_raddr", {24'd0, r_addr}, 32'd0);
    rst = 1'b0;
    op_ready = 1'b1;
    pairs.delete();
    start_burst(8'd10, 8'd1, 8'd14, 8'd1, 8'd1);
    check("restart_busy", {31'd0, busy}, 32'd1);
    wait_done("restart");
    check_pairs("restart", 1, 16'h0A05, 16'h0000, 16'h0000);

    // Address wrap: A reads 255 then 0, B reads 16 then 17.
    pairs.delete();
    start_burst(8'd255, 8'd1, 8'd16, 8'd1, 8'd2);
    wait_done("wrap");
    check_pairs("wrap", 2, 16'h4D01, 16'h6302, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
